// File: rtl/noc_out_arbiter.sv
// Round-robin output-port arbiter: pops one non-empty input FIFO per cycle into a
// single-entry output register and pushes it downstream over a write/full interface.
module noc_out_arbiter #(
  parameter  int N_IN   = 4,
  parameter  int FLIT_W = 32,
  parameter  int CNT_W  = 16,
  localparam int SRC_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in_empty,
  input  logic [N_IN*FLIT_W-1:0] in_item,
  output logic [N_IN-1:0]        in_read,
  output logic [FLIT_W-1:0]      out_item,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_write,
  input  logic                   out_full,
  output logic [CNT_W-1:0]       fwd_count
);

  logic             out_valid;
  logic [SRC_W-1:0] rr_ptr;
  logic             can_load;
  logic             transfer;
  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] rr_next;
  int               idx;

  assign can_load  = !out_valid || !out_full;
  assign transfer  = out_valid && !out_full;
  assign out_write = out_valid;

  // Search from rr_ptr upward with wrap-around; the first non-empty input wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    in_read   = '0;
    if (!reset && can_load) begin
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        cand = SRC_W'(idx);
        if (!grant_any && !in_empty[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) in_read[grant_idx] = 1'b1;
  end

  assign rr_next = (grant_idx == SRC_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_item  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
      fwd_count <= '0;
    end else begin
      // A grant replaces the output register even while its old flit leaves.
      if (grant_any) begin
        out_item  <= in_item[int'(grant_idx)*FLIT_W +: FLIT_W];
        out_src   <= grant_idx;
        out_valid <= 1'b1;
        rr_ptr    <= rr_next;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
      if (transfer && (fwd_count != {CNT_W{1'b1}})) fwd_count <= fwd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Bench for noc_out_arbiter: FIFO-model stimulus, reference arbitration model and a
// scoreboard of granted flits compared when each flit leaves the output stage.
module tb_noc_out_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_item;
  logic [N-1:0]   in_read, in_read_s;
  logic [W-1:0]   out_item, out_item_s;
  logic [SW-1:0]  out_src, out_src_s;
  logic           out_write, out_write_s;
  logic           out_full;
  logic [15:0]    fwd_count;
  logic [3:0]     fwd_count_s;

  always #5 clk = ~clk;

  noc_out_arbiter #(.N_IN(N), .FLIT_W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_item(in_item),
    .in_read(in_read), .out_item(out_item), .out_src(out_src),
    .out_write(out_write), .out_full(out_full), .fwd_count(fwd_count)
  );

  // Same stimulus, narrow counter, for saturation.
  noc_out_arbiter #(.N_IN(N), .FLIT_W(W), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_item(in_item),
    .in_read(in_read_s), .out_item(out_item_s), .out_src(out_src_s),
    .out_write(out_write_s), .out_full(out_full), .fwd_count(fwd_count_s)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0]    q [N][$];
  logic [SW+W-1:0] sb [$];
  int              glog [$];
  logic            m_valid;
  int              m_rr;
  int              m_cnt;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() == 0) begin
        in_empty[i]       = 1'b1;
        in_item[i*W +: W] = '0;
      end else begin
        in_empty[i]       = 1'b0;
        in_item[i*W +: W] = q[i][0];
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rr    = 0;
    m_cnt   = 0;
    sb.delete();
    glog.delete();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic push_flits(input int src, input int n);
    for (int j = 0; j < n; j++) q[src].push_back({8'(src), 8'h5C, 16'(q[src].size() + j * 7 + 1)});
  endtask

  function automatic bit busy();
    bit b = m_valid;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // One clock cycle, entered and left at the negedge.
  task automatic step();
    int g;
    logic [N-1:0]    exp_rd;
    logic [SW+W-1:0] exp_out;
    logic            xfer;
    #1;
    g = -1;
    if (!m_valid || !out_full)
      for (int k = 0; k < N; k++)
        if (g < 0 && q[(m_rr + k) % N].size() != 0) g = (m_rr + k) % N;
    exp_rd = '0;
    if (g >= 0) exp_rd[g] = 1'b1;
    checks++;
    if (in_read !== exp_rd) begin
      errors++;
      $display("FAIL in_read at %0t: got %b expected %b", $time, in_read, exp_rd);
    end
    checks++;
    if (in_read_s !== exp_rd) begin
      errors++;
      $display("FAIL in_read_sat at %0t: got %b expected %b", $time, in_read_s, exp_rd);
    end
    checks++;
    if (out_write !== m_valid) begin
      errors++;
      $display("FAIL out_write at %0t: got %b expected %b", $time, out_write, m_valid);
    end
    for (int i = 0; i < N; i++) if (in_read[i] === 1'b1) glog.push_back(i);
    xfer = m_valid && !out_full;
    if (m_valid && sb.size() != 0) begin
      exp_out = sb[0];
      checks++;
      if ({out_src, out_item} !== exp_out) begin
        errors++;
        $display("FAIL out_flit at %0t: got src=%0d item=%h expected src=%0d item=%h",
                 $time, out_src, out_item, exp_out[SW+W-1:W], exp_out[W-1:0]);
      end
      if (xfer) void'(sb.pop_front());
    end
    if (g >= 0) begin
      sb.push_back({SW'(g), q[g][0]});
      m_rr    = (g + 1) % N;
      m_valid = 1'b1;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (xfer) m_cnt++;
    @(posedge clk);
    #1;
    if (g >= 0) void'(q[g].pop_front());
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic check_counts(input string name);
    int exp_main = (m_cnt > 65535) ? 65535 : m_cnt;
    int exp_sat  = (m_cnt > 15) ? 15 : m_cnt;
    checks++;
    if (fwd_count !== 16'(exp_main)) begin
      errors++;
      $display("FAIL %s fwd_count: got %0d expected %0d", name, fwd_count, exp_main);
    end
    checks++;
    if (fwd_count_s !== 4'(exp_sat)) begin
      errors++;
      $display("FAIL %s fwd_count_sat: got %0d expected %0d", name, fwd_count_s, exp_sat);
    end
  endtask

  task automatic check_glog(input string name, input int exp_q[$]);
    checks++;
    if (glog.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s grant_count: got %0d expected %0d", name, glog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (glog[i] != exp_q[i]) begin
          errors++;
          $display("FAIL %s grant[%0d]: got %0d expected %0d", name, i, glog[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    out_full = 1'b0;
    model_reset();
    clear_queues();
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_full = 1'b0;
    model_reset();
    clear_queues();
    push_flits(1, 1);
    drive_inputs();
    #1;
    checks++;
    if (in_read !== 4'b0000 || out_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got in_read=%b out_write=%b expected 0000 0", in_read, out_write);
    end
    checks++;
    if (out_item !== '0 || out_src !== '0 || fwd_count !== '0) begin
      errors++;
      $display("FAIL reset_regs: got item=%h src=%0d cnt=%0d expected 0 0 0", out_item, out_src, fwd_count);
    end
    clear_queues();
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) step();
    check_counts("idle");
  endtask

  task automatic test_single();
    int n;
    int exp_q[$];
    reset_dut();
    q[2].push_back(32'hA1);
    q[2].push_back(32'hA2);
    q[2].push_back(32'hA3);
    drive_inputs();
    drain(20, n);
    exp_q = '{2, 2, 2};
    check_glog("single", exp_q);
    checks++;
    if (fwd_count !== 16'd3) begin
      errors++;
      $display("FAIL single_count: got %0d expected 3", fwd_count);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_q[$];
    reset_dut();
    for (int i = 0; i < N; i++) push_flits(i, 4);
    drive_inputs();
    drain(40, n);
    for (int i = 0; i < 16; i++) exp_q.push_back(i % N);
    check_glog("round_robin", exp_q);
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL rr_throughput: got %0d cycles expected 17", n);
    end
    checks++;
    if (fwd_count !== 16'd16) begin
      errors++;
      $display("FAIL rr_count: got %0d expected 16", fwd_count);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int exp_q[$];
    reset_dut();
    for (int i = 0; i < N; i++) push_flits(i, 3);
    drive_inputs();
    repeat (2) step();
    out_full = 1'b1;
    repeat (5) step();
    out_full = 1'b0;
    drain(40, n);
    for (int i = 0; i < 12; i++) exp_q.push_back(i % N);
    check_glog("backpressure", exp_q);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL bp_throughput: got %0d cycles expected 11", n);
    end
    check_counts("backpressure");
  endtask

  task automatic test_wrap_skip();
    int n;
    int exp_q[$];
    reset_dut();
    push_flits(2, 1);
    drive_inputs();
    drain(10, n);
    glog.delete();
    push_flits(1, 2);
    push_flits(3, 2);
    drive_inputs();
    drain(20, n);
    exp_q = '{3, 1, 3, 1};
    check_glog("wrap_skip", exp_q);
  endtask

  task automatic test_saturation();
    int n;
    reset_dut();
    for (int i = 0; i < N; i++) push_flits(i, 5);
    drive_inputs();
    drain(60, n);
    check_counts("saturation");
    checks++;
    if (fwd_count_s !== 4'd15 || fwd_count !== 16'd20) begin
      errors++;
      $display("FAIL sat_hold: got sat=%0d main=%0d expected 15 20", fwd_count_s, fwd_count);
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    push_flits(0, 5);
    drive_inputs();
    repeat (3) step();
    check_counts("pre_reset");
    reset = 1'b1;
    #1;
    checks++;
    if (out_write !== 1'b0 || in_read !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_strobes: got out_write=%b in_read=%b expected 0 0000", out_write, in_read);
    end
    checks++;
    if (fwd_count !== '0 || fwd_count_s !== '0) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d/%0d expected 0/0", fwd_count, fwd_count_s);
    end
    model_reset();
    clear_queues();
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    check_counts("post_reset");
  endtask

  initial begin
    reset    = 1'b1;
    out_full = 1'b0;
    in_empty = '1;
    in_item  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_saturation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Round-robin output-port arbiter for the router. It sits between N_IN input flit FIFOs (upstream) and one downstream FIFO or link register (downstream).
- Each cycle it picks one non-empty input FIFO and pops its head flit (read/empty interface). It registers the flit into a single-entry output stage and pushes it downstream over a write/full interface.
- It keeps a saturating count of forwarded flits for debug.

Parameters:
- N_IN, 4, number of input FIFOs arbitrated (2..8).
- FLIT_W, 32, flit width; equals header+payload+address width of the router FIFOs.
- CNT_W, 16, width of the forwarded-flit counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_empty  input  N_IN  per-input FIFO empty flag; bit i belongs to input i.
- in_item  input  N_IN*FLIT_W  per-input FIFO head flit; slice i is [i*FLIT_W +: FLIT_W]; valid when in_empty[i]=0.
- in_read  output  N_IN  one-hot pop strobe to the input FIFOs; combinational.
- out_item  output  FLIT_W  registered flit presented downstream.
- out_src  output  log2(N_IN) (min 1)  index of the input that out_item came from.
- out_write  output  1  downstream push strobe; equals out_valid.
- out_full  input  1  downstream FIFO full flag.
- fwd_count  output  CNT_W  saturating count of flits accepted downstream.

Behaviour:
- Reset (async): out_valid=0, out_item=0, out_src=0, rr_ptr=0, fwd_count=0. in_read=0 while reset is high.
- Transfer out: a flit leaves when out_valid=1 and out_full=0 at a posedge.
- Output stage can load when can_load = !out_valid | !out_full.
- Arbitration (combinational): req = ~in_empty. If can_load and req!=0, grant is the first set bit of req searching from rr_ptr upward, with wrap-around mod N_IN. Otherwise grant=0.
- in_read = grant. At most one bit is set; never asserted for an empty input and never asserted when can_load=0.
- On posedge with grant!=0:
  - out_item <= in_item slice of the granted index g; out_src <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod N_IN.
  - The input FIFO pops on the same edge. Input-pop to out_write latency is 1 cycle.
- On posedge with a transfer out and grant=0: out_valid <= 0. out_item and out_src hold their values.
- Simultaneous transfer out and grant: the output register is replaced in the same cycle. This gives full throughput of one flit per cycle when downstream is not full.
- out_full=1 with out_valid=1: out_item, out_src and out_valid hold. in_read=0. rr_ptr holds. No flit is lost or duplicated.
- out_full is sampled as-is. The arbiter never writes while out_full=1, and downstream must ignore out_write while full.
- fwd_count increments by 1 on each transfer out. It saturates at 2^CNT_W-1 and never wraps.
- rr_ptr changes only on a grant. Idle cycles do not rotate priority.
- Fairness: with all inputs continuously non-empty and out_full=0, grants cycle 0,1,...,N_IN-1,0 in that order.
- Reset asserted mid-operation: every register clears immediately. A flit held in the output stage is discarded.
- All flit data is passed unmodified; no arithmetic is performed on it.

Test Plan:
- Reset then idle: all in_empty=1 for 10 cycles -> in_read=0, out_write=0, fwd_count=0.
- Single input: input 2 holds 3 flits 0xA1, 0xA2, 0xA3; out_full=0 -> in_read=0b0100 for 3 consecutive cycles; out_item 0xA1, 0xA2, 0xA3 on the following cycles with out_src=2; fwd_count=3.
- Round-robin: all 4 inputs non-empty with 4 flits each; out_full=0 -> grant order 0,1,2,3,0,1,2,3,...; 16 flits delivered in 16 consecutive cycles; fwd_count=16.
- Backpressure: out_full=1 for 5 cycles while out_valid=1 and inputs are non-empty -> in_read=0 and out_item stable for all 5 cycles; after release, exactly one write per cycle, no loss or duplication; sequence checked against a scoreboard.
- Wrap and skip: rr_ptr=3, only inputs 1 and 3 non-empty -> grant 3 then 1 then 3; input 0 is never read while empty.
- Saturation and mid-reset: with CNT_W=4, forward 20 flits -> fwd_count holds 15. Assert reset while out_valid=1 -> out_write drops in the same cycle and fwd_count=0.
